// File: rtl/dpram_be_sc.sv
// Single-clock true dual-port RAM with per-byte write enables, selectable
// read-during-write behaviour and a sequential clear engine.
// Ports:
//   clk, rst_n          - shared clock, asynchronous active-low reset
//   clr_req / clr_busy  - start a clear sweep / sweep in progress
//   we_x, be_x, addr_x  - port x write strobe, byte enables, word address
//   din_x / dout_x      - port x write data / registered read data
module dpram_be_sc #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit BYPASS = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int unsigned NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  clr_busy,
  input  logic                  we_a,
  input  logic [NB-1:0]         be_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  we_b,
  input  logic [NB-1:0]         be_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pend_q;
  logic                  busy_d;
  logic                  active_c;
  logic [NB-1:0]         wa_c, wb_c;
  logic [DATA_WIDTH-1:0] rd_a_c, rd_b_c;

  // Word at address ra after this cycle's writes; A wins overlapping lanes.
  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [ADDR_WIDTH-1:0] ra,
    input logic [ADDR_WIDTH-1:0] wa_addr,
    input logic [NB-1:0]         wa_en,
    input logic [DATA_WIDTH-1:0] wa_data,
    input logic [ADDR_WIDTH-1:0] wb_addr,
    input logic [NB-1:0]         wb_en,
    input logic [DATA_WIDTH-1:0] wb_data
  );
    logic [DATA_WIDTH-1:0] w;
    w = old;
    for (int i = 0; i < int'(NB); i++) begin
      if (wa_en[i] && (wa_addr == ra)) begin
        w[8*i +: 8] = wa_data[8*i +: 8];
      end else if (wb_en[i] && (wb_addr == ra)) begin
        w[8*i +: 8] = wb_data[8*i +: 8];
      end
    end
    return w;
  endfunction

  // Sweep is active in SWEEP or on the first edge after a reset that
  // requested an automatic clear (pend_q).
  assign active_c = (state_q == SWEEP) || pend_q;

  // External lane enables, dropped while the sweep owns the array.
  always_comb begin
    wa_c = '0;
    wb_c = '0;
    if (!active_c) begin
      wa_c = we_a ? be_a : '0;
      wb_c = we_b ? be_b : '0;
    end
  end

  always_comb begin
    rd_a_c = merge(mem[addr_a], addr_a, addr_a, wa_c, din_a, addr_b, wb_c, din_b);
    rd_b_c = merge(mem[addr_b], addr_b, addr_a, wa_c, din_a, addr_b, wb_c, din_b);
  end

  // Clear engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= CLEAR_ON_RESET;
      clr_busy <= CLEAR_ON_RESET;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= 1'b0;
      clr_busy <= busy_d;
    end
  end

  // Clear engine next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          // Auto-clear writes address cnt_q on this very edge.
          state_d = SWEEP;
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
        end else if (clr_req) begin
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SWEEP);
  end

  // Array: not reset; initialised only by the sweep.
  always_ff @(posedge clk) begin
    if (active_c) begin
      mem[cnt_q] <= CLEAR_VALUE;
    end
    for (int i = 0; i < int'(NB); i++) begin
      if (wa_c[i]) begin
        mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
      end
      if (wb_c[i] && !(wa_c[i] && (addr_a == addr_b))) begin
        mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
      end
    end
  end

  // Registered read ports; forced to the clear word during a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a <= '0;
      dout_b <= '0;
    end else if (active_c) begin
      dout_a <= CLEAR_VALUE;
      dout_b <= CLEAR_VALUE;
    end else if (BYPASS) begin
      dout_a <= rd_a_c;
      dout_b <= rd_b_c;
    end else begin
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
    end
  end

endmodule

// File: tb/tb_dpram_be_sc.sv
// Directed self-checking bench: u1 is the forwarding variant, u0 the
// read-old-data variant; both share every input.
module tb_dpram_be_sc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_req;
  logic        we_a, we_b;
  logic [1:0]  be_a, be_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b;
  logic        busy1, busy0;
  logic [15:0] da1, db1, da0, db0;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  dpram_be_sc #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYPASS(1'b1),
                .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h0000)) u1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy1),
    .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(da1),
    .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(db1));

  dpram_be_sc #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYPASS(1'b0),
                .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h0000)) u0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy0),
    .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(da0),
    .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(db0));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0;
    we_a = 1'b0; be_a = 2'b00; din_a = '0;
    we_b = 1'b0; be_b = 2'b00; din_b = '0;
  endtask

  // Ticks until both DUTs drop clr_busy; returns edges counted.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((busy1 || busy0) && cnt < 100);
  endtask

  initial begin
    rst_n = 1'b0;
    addr_a = '0; addr_b = '0;
    idle_inputs();

    // Reset values: pending auto-clear visible, read ports zero.
    tick(); tick();
    chk("rst_busy1", 16'(busy1), 16'h0001);
    chk("rst_busy0", 16'(busy0), 16'h0001);
    chk("rst_dout_a", da1, 16'h0000);
    chk("rst_dout_b", db0, 16'h0000);

    rst_n = 1'b1;
    wait_idle(n);
    chk("autoclr_len1", 16'(n), 16'd16);

    // Fill all words with 0xFFFF, then reset to re-run the auto-clear.
    for (int i = 0; i < 16; i++) begin
      we_a = 1'b1; be_a = 2'b11; addr_a = 4'(i); din_a = 16'hFFFF;
      tick();
    end
    idle_inputs();
    addr_a = 4'd9;
    tick(); tick();
    chk("preload_rd9", da0, 16'hFFFF);

    rst_n = 1'b0;
    tick();
    chk("rst2_busy", 16'(busy1), 16'h0001);
    rst_n = 1'b1;
    wait_idle(n);
    chk("autoclr_len2", 16'(n), 16'd16);
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i); addr_b = 4'(15 - i);
      tick();
      chk("clr_rd_a1", da1, 16'h0000);
      chk("clr_rd_b0", db0, 16'h0000);
    end

    // Byte-lane merge on one port.
    we_a = 1'b1; be_a = 2'b11; addr_a = 4'd3; din_a = 16'h1234;
    tick();
    we_a = 1'b1; be_a = 2'b10; addr_a = 4'd3; din_a = 16'hAB00;
    tick();
    chk("rdw_own_byp1", da1, 16'hAB34);
    chk("rdw_own_byp0", da0, 16'h1234);
    idle_inputs();
    tick();
    chk("merge3_a1", da1, 16'hAB34);
    chk("merge3_a0", da0, 16'hAB34);

    // Dual-port same-address collision, A wins overlapping lane.
    we_a = 1'b1; be_a = 2'b10; addr_a = 4'd5; din_a = 16'h1100;
    we_b = 1'b1; be_b = 2'b11; addr_b = 4'd5; din_b = 16'h22FF;
    tick();
    chk("coll_byp1_a", da1, 16'h11FF);
    chk("coll_byp1_b", db1, 16'h11FF);
    chk("coll_byp0_a", da0, 16'h0000);
    chk("coll_byp0_b", db0, 16'h0000);
    idle_inputs();
    tick();
    chk("coll_rd_a0", da0, 16'h11FF);
    chk("coll_rd_b1", db1, 16'h11FF);

    // Write on A while B reads the same word.
    we_a = 1'b1; be_a = 2'b11; addr_a = 4'd7; din_a = 16'h5555;
    addr_b = 4'd7;
    tick();
    chk("xrdw_b0_old", db0, 16'h0000);
    chk("xrdw_b1_fwd", db1, 16'h5555);
    idle_inputs();
    tick();
    chk("xrdw_b0_new", db0, 16'h5555);

    // we with no byte enables is a no-op.
    we_a = 1'b1; be_a = 2'b00; addr_a = 4'd5; din_a = 16'hFFFF;
    tick();
    idle_inputs();
    tick();
    chk("be0_noop", da0, 16'h11FF);

    // Sweep with dropped write and ignored second request.
    we_a = 1'b1; be_a = 2'b11; addr_a = 4'd2; din_a = 16'h2222;
    tick();
    idle_inputs();
    clr_req = 1'b1; addr_a = 4'd3;
    tick();
    clr_req = 1'b0;
    chk("clr_busy_T1", 16'(busy1), 16'h0001);
    n = 0;
    do begin
      idle_inputs();
      addr_a = 4'd3;
      if (n == 3) begin
        we_a = 1'b1; be_a = 2'b11; addr_a = 4'd2; din_a = 16'h7777;
      end
      if (n == 8) clr_req = 1'b1;
      tick();
      n++;
      if (n == 5) chk("sweep_dout_forced", da1, 16'h0000);
    end while ((busy1 || busy0) && n < 100);
    idle_inputs();
    chk("clr_req_len", 16'(n), 16'd16);
    addr_a = 4'd2; addr_b = 4'd3;
    tick();
    chk("drop_wr_a2_1", da1, 16'h0000);
    chk("drop_wr_a2_0", da0, 16'h0000);
    chk("cleared3", db1, 16'h0000);
    addr_a = 4'd5; addr_b = 4'd7;
    tick();
    chk("cleared5", da0, 16'h0000);
    chk("cleared7", db0, 16'h0000);

    // Reset mid-sweep restarts a full sweep.
    we_a = 1'b1; be_a = 2'b11; addr_a = 4'd12; din_a = 16'hCCCC;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 16'(busy1), 16'h0001);
    chk("midrst_dout", da1, 16'h0000);
    tick();
    rst_n = 1'b1;
    wait_idle(n);
    chk("restart_len", 16'(n), 16'd16);
    addr_a = 4'd12;
    tick();
    chk("restart_rd12", da1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
